// File: rtl/bank_arb_pkg.sv
// rtl/bank_arb_pkg.sv - shared types and default sizes for the bank write arbiter
//
// Purpose : requester and arbiter-state enumerations plus default width
//           constants used by bank_write_arbiter and wr_slot.
// Ports   : none (package).
package bank_arb_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 4;
  localparam int DEF_STAT_ADDR  = 0;
  localparam int DEF_MAX_WAIT   = 8;
  localparam int DEF_CNT_WIDTH  = 8;

  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ_DEC  = 2'd1,
    REQ_SPI  = 2'd2
  } req_t;

  typedef enum logic {
    FAVOR_DEC = 1'b0,
    FAVOR_SPI = 1'b1
  } arb_state_t;

endpackage

// File: rtl/bank_write_arbiter_wr_slot.sv
// rtl/bank_write_arbiter_wr_slot.sv - one-entry write holding slot with valid/ready
//
// Purpose : holds one pending register write until the arbiter grants it.
// Ports   : i_clk, i_rst          clock, async active-high reset
//           i_valid/o_ready       write handshake from the requester
//           i_discard             accept the beat but do not store it
//           i_addr/i_data         write address/data from the requester
//           i_grant               arbiter takes the stored entry this cycle
//           o_full/o_addr/o_data  stored entry towards the arbiter
module wr_slot #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  input  logic                  i_discard,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_ready,
  input  logic                  i_grant,
  output logic                  o_full,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic [DATA_WIDTH-1:0] o_data
);

  logic                  r_full;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  w_accept;

  // The slot frees up in the same cycle it is granted, so a requester that
  // keeps valid high can move one write per cycle.
  assign o_ready  = !r_full || i_grant;
  assign w_accept = i_valid && o_ready;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_full <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
    end else if (w_accept && !i_discard) begin
      r_full <= 1'b1;
      r_addr <= i_addr;
      r_data <= i_data;
    end else if (i_grant) begin
      r_full <= 1'b0;
    end
  end

  assign o_full = r_full;
  assign o_addr = r_addr;
  assign o_data = r_data;

endmodule

// File: rtl/bank_write_arbiter.sv
// rtl/bank_write_arbiter.sv - arbitrates decoder and SPI writes onto the register bank port
//
// Purpose : serialises decoder and SPI writes through one-entry slots onto a
//           single bank write port, drops SPI writes to the status register
//           and counts cycles where both slots are occupied.
// Macro   : BANK_ARB_STARVE_GUARD_EN enables the SPI starvation guard
//           (wait counter forcing FAVOR_SPI); undefined = strict decoder priority.
// Ports   : i_clk, i_reset                      clock, async active-high reset
//           i_dec_wr_valid/addr/data, o_dec_wr_ready   decoder write handshake
//           i_spi_wr_valid/addr/data, o_spi_wr_ready   SPI write handshake
//           o_bank_wr_en/addr/data              registered bank write port
//           o_spi_wr_denied                     pulse: SPI status write dropped
//           o_conflict_count                    saturating both-full cycle count
module bank_write_arbiter
  import bank_arb_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int STAT_ADDR  = DEF_STAT_ADDR,
  parameter int MAX_WAIT   = DEF_MAX_WAIT,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_dec_wr_valid,
  input  logic [ADDR_WIDTH-1:0] i_dec_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_dec_wr_data,
  output logic                  o_dec_wr_ready,
  input  logic                  i_spi_wr_valid,
  input  logic [ADDR_WIDTH-1:0] i_spi_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_spi_wr_data,
  output logic                  o_spi_wr_ready,
  output logic                  o_bank_wr_en,
  output logic [ADDR_WIDTH-1:0] o_bank_wr_addr,
  output logic [DATA_WIDTH-1:0] o_bank_wr_data,
  output logic                  o_spi_wr_denied,
  output logic [CNT_WIDTH-1:0]  o_conflict_count
);

  logic                  w_dec_full;
  logic [ADDR_WIDTH-1:0] w_dec_addr;
  logic [DATA_WIDTH-1:0] w_dec_data;
  logic                  w_spi_full;
  logic [ADDR_WIDTH-1:0] w_spi_addr;
  logic [DATA_WIDTH-1:0] w_spi_data;
  logic                  w_spi_to_stat;
  logic                  w_spi_denied;
  req_t                  w_grant;
  arb_state_t            r_state;
  arb_state_t            w_state_next;

  logic                  r_bank_en;
  logic [ADDR_WIDTH-1:0] r_bank_addr;
  logic [DATA_WIDTH-1:0] r_bank_data;
  logic                  r_denied;
  logic [CNT_WIDTH-1:0]  r_conflict_cnt;

  // Status-register writes from SPI complete the handshake but are never stored.
  assign w_spi_to_stat = (i_spi_wr_addr == ADDR_WIDTH'(STAT_ADDR));
  assign w_spi_denied  = i_spi_wr_valid && o_spi_wr_ready && w_spi_to_stat;

  wr_slot #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_dec_slot (
    .i_clk     (i_clk),
    .i_rst     (i_reset),
    .i_valid   (i_dec_wr_valid),
    .i_discard (1'b0),
    .i_addr    (i_dec_wr_addr),
    .i_data    (i_dec_wr_data),
    .o_ready   (o_dec_wr_ready),
    .i_grant   (w_grant == REQ_DEC),
    .o_full    (w_dec_full),
    .o_addr    (w_dec_addr),
    .o_data    (w_dec_data)
  );

  wr_slot #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_spi_slot (
    .i_clk     (i_clk),
    .i_rst     (i_reset),
    .i_valid   (i_spi_wr_valid),
    .i_discard (w_spi_to_stat),
    .i_addr    (i_spi_wr_addr),
    .i_data    (i_spi_wr_data),
    .o_ready   (o_spi_wr_ready),
    .i_grant   (w_grant == REQ_SPI),
    .o_full    (w_spi_full),
    .o_addr    (w_spi_addr),
    .o_data    (w_spi_data)
  );

`ifdef BANK_ARB_STARVE_GUARD_EN
  localparam int WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

  logic [WAIT_W-1:0] r_wait_cnt;
  logic              w_wait_expired;

  assign w_wait_expired = (r_wait_cnt == WAIT_W'(MAX_WAIT - 1));

  // Counts cycles the SPI entry sits in its slot without being granted;
  // it holds at the threshold until the forced grant clears it.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_wait_cnt <= '0;
    end else if (w_grant == REQ_SPI) begin
      r_wait_cnt <= '0;
    end else if (w_spi_full && !w_wait_expired) begin
      r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
    end
  end
`endif

  // FSM: state register
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= FAVOR_DEC;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM: next state
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      FAVOR_DEC: begin
`ifdef BANK_ARB_STARVE_GUARD_EN
        if (w_wait_expired && (w_grant != REQ_SPI)) begin
          w_state_next = FAVOR_SPI;
        end
`endif
      end
      FAVOR_SPI: begin
        if (w_grant == REQ_SPI) begin
          w_state_next = FAVOR_DEC;
        end
      end
      default: w_state_next = FAVOR_DEC;
    endcase
  end

  // FSM: grant output
  always_comb begin
    w_grant = REQ_NONE;
    case (r_state)
      FAVOR_SPI: begin
        if (w_spi_full) begin
          w_grant = REQ_SPI;
        end else if (w_dec_full) begin
          w_grant = REQ_DEC;
        end
      end
      default: begin
        if (w_dec_full) begin
          w_grant = REQ_DEC;
        end else if (w_spi_full) begin
          w_grant = REQ_SPI;
        end
      end
    endcase
  end

  // Bank port registers; address/data only move on a grant so they hold
  // the last written values while the strobe is low.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_bank_en      <= 1'b0;
      r_bank_addr    <= '0;
      r_bank_data    <= '0;
      r_denied       <= 1'b0;
      r_conflict_cnt <= '0;
    end else begin
      r_bank_en <= (w_grant != REQ_NONE);
      r_denied  <= w_spi_denied;
      if (w_grant == REQ_DEC) begin
        r_bank_addr <= w_dec_addr;
        r_bank_data <= w_dec_data;
      end else if (w_grant == REQ_SPI) begin
        r_bank_addr <= w_spi_addr;
        r_bank_data <= w_spi_data;
      end
      if (w_dec_full && w_spi_full && (r_conflict_cnt != '1)) begin
        r_conflict_cnt <= r_conflict_cnt + CNT_WIDTH'(1);
      end
    end
  end

  assign o_bank_wr_en     = r_bank_en;
  assign o_bank_wr_addr   = r_bank_addr;
  assign o_bank_wr_data   = r_bank_data;
  assign o_spi_wr_denied  = r_denied;
  assign o_conflict_count = r_conflict_cnt;

endmodule

// File: tb/tb_bank_write_arbiter.sv
// tb/tb_bank_write_arbiter.sv - scoreboard bench for bank_write_arbiter
module tb_bank_write_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dec_valid = 1'b0;
  logic [3:0]  dec_addr  = '0;
  logic [31:0] dec_data  = '0;
  logic        dec_ready;
  logic        spi_valid = 1'b0;
  logic [3:0]  spi_addr  = '0;
  logic [31:0] spi_data  = '0;
  logic        spi_ready;
  logic        bank_en;
  logic [3:0]  bank_addr;
  logic [31:0] bank_data;
  logic        spi_denied;
  logic [7:0]  conflict_count;

  bank_write_arbiter dut (
    .i_clk            (clk),
    .i_reset          (rst),
    .i_dec_wr_valid   (dec_valid),
    .i_dec_wr_addr    (dec_addr),
    .i_dec_wr_data    (dec_data),
    .o_dec_wr_ready   (dec_ready),
    .i_spi_wr_valid   (spi_valid),
    .i_spi_wr_addr    (spi_addr),
    .i_spi_wr_data    (spi_data),
    .o_spi_wr_ready   (spi_ready),
    .o_bank_wr_en     (bank_en),
    .o_bank_wr_addr   (bank_addr),
    .o_bank_wr_data   (bank_data),
    .o_spi_wr_denied  (spi_denied),
    .o_conflict_count (conflict_count)
  );

  always #5 clk = ~clk;

  // Expected bank writes per requester, {addr, data}. Decoder data always has
  // bit 31 clear and SPI data bit 31 set, so the monitor knows the source.
  logic [35:0] q_dec[$];
  logic [35:0] q_spi[$];
  int n_checks = 0;
  int n_pass = 0;
  int exp_denied = 0;
  int seen_denied = 0;
  int n_writes = 0;
  int n_spi_writes = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
  endtask

  // Monitor: every bank strobe must match the oldest outstanding write of its source.
  always @(negedge clk) begin
    if (!rst) begin
      if (spi_denied) seen_denied++;
      if (bank_en) begin
        n_writes++;
        if (bank_data[31]) begin
          n_spi_writes++;
          chk("spi_write_expected", 64'(q_spi.size() != 0), 64'd1);
          if (q_spi.size() != 0) chk("spi_write", {28'd0, bank_addr, bank_data}, {28'd0, q_spi.pop_front()});
        end else begin
          chk("dec_write_expected", 64'(q_dec.size() != 0), 64'd1);
          if (q_dec.size() != 0) chk("dec_write", {28'd0, bank_addr, bank_data}, {28'd0, q_dec.pop_front()});
        end
      end
    end
  end

  // One clock of stimulus: called at posedge+1, samples ready at negedge,
  // records what the next posedge transfers, returns at the following posedge+1.
  task automatic cycle(input logic dv, input logic [3:0] da, input logic [31:0] dd,
                       input logic sv, input logic [3:0] sa, input logic [31:0] sd,
                       output logic dacc, output logic sacc);
    dec_valid = dv; dec_addr = da; dec_data = dd;
    spi_valid = sv; spi_addr = sa; spi_data = sd;
    @(negedge clk);
    dacc = dv && dec_ready;
    sacc = sv && spi_ready;
    if (dacc) q_dec.push_back({da, dd});
    if (sacc) begin
      if (sa == 4'd0) exp_denied++;
      else q_spi.push_back({sa, sd});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    logic a, b;
    for (int i = 0; i < n; i++) cycle(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, a, b);
  endtask

  function automatic logic [31:0] rdec();
    return $urandom & 32'h7FFF_FFFF;
  endfunction

  function automatic logic [31:0] rspi();
    return $urandom | 32'h8000_0000;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic da, sa;
    int w0;
    logic        pd_v, ps_v;
    logic [3:0]  pd_a, ps_a;
    logic [31:0] pd_d, ps_d;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_bank_en", bank_en, 0);
    chk("rst_bank_addr", bank_addr, 0);
    chk("rst_bank_data", bank_data, 0);
    chk("rst_denied", spi_denied, 0);
    chk("rst_conflict", conflict_count, 0);
    chk("rst_dec_ready", dec_ready, 1);
    chk("rst_spi_ready", spi_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single SPI write: strobe two edges after acceptance, address/data hold afterwards.
    cycle(1'b0, 4'd0, 32'd0, 1'b1, 4'd3, 32'hDEAD_BEEF, da, sa);
    chk("t1_accepted", sa, 1);
    chk("t1_en_T0", bank_en, 0);
    chk("t1_spi_ready", spi_ready, 1);
    idle(1);
    chk("t1_en_T1", bank_en, 1);
    chk("t1_addr", bank_addr, 3);
    chk("t1_data", bank_data, 32'hDEAD_BEEF);
    idle(1);
    chk("t1_en_T2", bank_en, 0);
    chk("t1_addr_hold", bank_addr, 3);
    chk("t1_data_hold", bank_data, 32'hDEAD_BEEF);

    // Simultaneous decoder/SPI writes: decoder first, SPI next, one conflict cycle.
    cycle(1'b1, 4'd5, 32'h0000_0555, 1'b1, 4'd6, 32'h8000_0666, da, sa);
    chk("t2_both_accepted", {da, sa}, 2'b11);
    idle(1);
    chk("t2_first_en", bank_en, 1);
    chk("t2_first_addr", bank_addr, 5);
    chk("t2_conflict", conflict_count, 1);
    idle(1);
    chk("t2_second_en", bank_en, 1);
    chk("t2_second_addr", bank_addr, 6);
    chk("t2_conflict_hold", conflict_count, 1);
    idle(1);
    chk("t2_done_en", bank_en, 0);

    // SPI write to the status register is accepted and dropped.
    cycle(1'b0, 4'd0, 32'd0, 1'b1, 4'd0, 32'h8000_1234, da, sa);
    chk("t3_accepted", sa, 1);
    chk("t3_denied_pulse", spi_denied, 1);
    chk("t3_no_write0", bank_en, 0);
    idle(1);
    chk("t3_denied_end", spi_denied, 0);
    chk("t3_no_write1", bank_en, 0);
    cycle(1'b0, 4'd0, 32'd0, 1'b1, 4'd2, 32'h8000_0002, da, sa);
    idle(1);
    chk("t3_next_en", bank_en, 1);
    chk("t3_next_addr", bank_addr, 2);

    // Continuous decoder traffic against one pending SPI write.
    idle(2);
    w0 = n_spi_writes;
    cycle(1'b1, 4'($urandom_range(1, 15)), rdec(), 1'b1, 4'd7, 32'h8000_0777, da, sa);
    for (int i = 0; i < 14; i++) cycle(1'b1, 4'($urandom), rdec(), 1'b0, 4'd0, 32'd0, da, sa);
`ifdef BANK_ARB_STARVE_GUARD_EN
    chk("t4_guard_spi_granted", n_spi_writes - w0, 1);
`else
    chk("t4_spi_starved", n_spi_writes - w0, 0);
    chk("t4_spi_ready_low", spi_ready, 0);
`endif
    idle(6);
    chk("t4_drained", q_dec.size() + q_spi.size(), 0);

    // Reset with a strobe in flight and the SPI slot still full.
    cycle(1'b1, 4'd9, 32'h0000_0999, 1'b1, 4'd10, 32'h8000_0AAA, da, sa);
    idle(1);
    chk("t5_pre_en", bank_en, 1);
    #2;
    rst = 1'b1;
    q_dec.delete();
    q_spi.delete();
    #1;
    chk("t5_rst_en", bank_en, 0);
    chk("t5_rst_addr", bank_addr, 0);
    chk("t5_rst_data", bank_data, 0);
    chk("t5_rst_dec_ready", dec_ready, 1);
    chk("t5_rst_spi_ready", spi_ready, 1);
    chk("t5_rst_conflict", conflict_count, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    w0 = n_writes;
    idle(6);
    chk("t5_no_stale_writes", n_writes - w0, 0);

    // Sustained conflicts saturate the counter.
    for (int i = 0; i < 300; i++)
      cycle(1'b1, 4'($urandom), rdec(), 1'b1, 4'($urandom_range(1, 15)), rspi(), da, sa);
    chk("t6_saturated", conflict_count, 255);
    idle(8);
    chk("t6_sat_hold", conflict_count, 255);
    chk("t6_drained", q_dec.size() + q_spi.size(), 0);

    // Random traffic; a payload is held until it is accepted.
    pd_v = 0; ps_v = 0; pd_a = 0; ps_a = 0; pd_d = 0; ps_d = 0;
    for (int i = 0; i < 400; i++) begin
      if (!pd_v && ($urandom_range(0, 1) == 1)) begin
        pd_v = 1; pd_a = 4'($urandom); pd_d = rdec();
      end
      if (!ps_v && ($urandom_range(0, 2) == 0)) begin
        ps_v = 1; ps_a = 4'($urandom); ps_d = rspi();
      end
      cycle(pd_v, pd_a, pd_d, ps_v, ps_a, ps_d, da, sa);
      if (da) pd_v = 0;
      if (sa) ps_v = 0;
    end
    for (int i = 0; i < 60 && (q_dec.size() + q_spi.size()) != 0; i++) idle(1);
    idle(2);
    chk("rand_drained", q_dec.size() + q_spi.size(), 0);
    chk("denied_total", seen_denied, exp_denied);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
